dram_arbiter: RTL and testbench
===============================

DRAM_ARBITER -- requirements
Module: dram_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, meaning the RAM address width (256 words).
REQ-002 The block SHALL have parameter DATA_W, default 32, meaning the RAM word width.
REQ-003 The block SHALL have port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, meaning asynchronous, active-high reset.
REQ-005 The block SHALL have ports req_a / req_b, input, 1, meaning requester A / B has an access pending.
REQ-006 The block SHALL have ports we_a / we_b, input, 1, meaning 1 = write and 0 = read, qualified by req_x.
REQ-007 The block SHALL have ports addr_a / addr_b, input, ADDR_W, meaning the access address.
REQ-008 The block SHALL have ports wdata_a / wdata_b, input, DATA_W, meaning the write data.
REQ-009 The block SHALL have ports gnt_a / gnt_b, output, 1, meaning the request was accepted this cycle (combinational).
REQ-010 The block SHALL have ports rvalid_a / rvalid_b, output, 1, meaning rdata carries that port's read result this cycle.
REQ-011 The block SHALL have port rdata, output, DATA_W, meaning the shared read data, valid only while an rvalid_x is high.

Function
REQ-012 The block SHALL grant at most one requester per cycle; gnt_a and gnt_b SHALL never be high together.
REQ-013 A request SHALL be accepted in a cycle when req_x and gnt_x are both high; the requester SHALL hold addr, we and wdata stable until then.
REQ-014 With only one requester active, that requester SHALL be granted in the same cycle (zero-cycle arbitration).
REQ-015 With both requesters active, the grant SHALL go to the port named by the priority register prio (0 = A, 1 = B).
REQ-016 After any grant, prio SHALL point to the non-granted port; with no grant, prio SHALL be unchanged (round-robin).
REQ-017 The granted port's we, addr and wdata SHALL drive the RAM; with no grant, the RAM write enable SHALL be 0.
REQ-018 A write SHALL update RAM at the edge ending the grant cycle and SHALL produce no rvalid.
REQ-019 A read accepted in cycle N SHALL assert rvalid_x for exactly one cycle, N+1, with rdata = mem[addr] as of edge N.
REQ-020 A read of an address written in the immediately preceding cycle SHALL return the new data.
REQ-021 rvalid_a and rvalid_b SHALL never be high together.
REQ-022 Back-to-back grants SHALL be allowed every cycle; sustained throughput SHALL be one access per cycle.
REQ-023 Under continuous contention, each port SHALL be granted in alternate cycles (no starvation, maximum wait 1 cycle).

Reset
REQ-024 While rst is high: prio = 0, rvalid_a = rvalid_b = 0, and the RAM write enable SHALL be forced to 0; gnt_x SHALL be 0.
REQ-025 A read accepted in the cycle rst asserts SHALL produce no rvalid after reset.
REQ-026 RAM contents SHALL not be cleared by reset.
REQ-027 rdata SHALL be treated as don't-care whenever both rvalid signals are low.

Structure
REQ-028 ADDR_W/DATA_W defaults and the port-select encoding (PORT_A = 0, PORT_B = 1) SHALL reside in the shared package dram_pkg.
REQ-029 The storage SHALL be one sub-module, dram_256x32: a distributed single-port RAM with a registered read port.
REQ-030 All arbitration, priority and rvalid pipeline logic SHALL reside in dram_arbiter.

Verification
REQ-031 A alone writes 0xDEADBEEF to 0x10, then reads 0x10 -> gnt_a is high in both cycles; rvalid_a is high one cycle after the read with rdata = 0xDEADBEEF.
REQ-032 Both request reads (A 0x01, B 0x02) for 4 cycles after reset -> the grant order is A, B, A, B; rvalid alternates one cycle later with the correct data.
REQ-033 B writes 0x55 to 0xFF in cycle N and A reads 0xFF in cycle N+1 -> rvalid_a in cycle N+2 with rdata = 0x55.
REQ-034 A read is granted and rst pulses on the next edge -> no rvalid is seen, and prio = 0 after reset.
REQ-035 Write and read boundary addresses 0x00 and 0xFF -> the data is correct with no aliasing.
REQ-036 Random traffic for 10k cycles against a scoreboard model -> no dual grant, no lost or extra rvalid, and data matches.

Source files
------------

// File: rtl/dram_pkg.sv
// Shared defaults and port-select encoding for the two-port DRAM arbiter.
package dram_pkg;

  localparam int unsigned DEF_ADDR_W = 8;
  localparam int unsigned DEF_DATA_W = 32;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_e;

endpackage : dram_pkg

// File: rtl/dram_256x32.sv
// Single-port distributed RAM with a registered read port; contents are never reset.
module dram_256x32 #(
  parameter int unsigned ADDR_W = dram_pkg::DEF_ADDR_W,
  parameter int unsigned DATA_W = dram_pkg::DEF_DATA_W
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  // Read returns the word as it was before this edge's write (single access per cycle).
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
    r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule : dram_256x32

// File: rtl/dram_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between requesters A and B.
module dram_arbiter
  import dram_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_a,
  input  logic              req_b,
  input  logic              we_a,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] wdata_a,
  input  logic [DATA_W-1:0] wdata_b,
  output logic              gnt_a,
  output logic              gnt_b,
  output logic              rvalid_a,
  output logic              rvalid_b,
  output logic [DATA_W-1:0] rdata
);

  port_e             r_prio;
  logic              r_rvalid_a;
  logic              r_rvalid_b;
  logic              w_gnt_a;
  logic              w_gnt_b;
  logic              w_ram_we;
  logic [ADDR_W-1:0] w_ram_addr;
  logic [DATA_W-1:0] w_ram_wdata;

  // Zero-cycle grant: a lone requester wins, contention resolved by r_prio; reset blocks all.
  always_comb begin
    w_gnt_a = 1'b0;
    w_gnt_b = 1'b0;
    if (!rst) begin
      w_gnt_a = req_a && (!req_b || (r_prio == PORT_A));
      w_gnt_b = req_b && (!req_a || (r_prio == PORT_B));
    end
  end

  always_comb begin
    w_ram_we    = (w_gnt_a && we_a) || (w_gnt_b && we_b);
    w_ram_addr  = w_gnt_b ? addr_b  : addr_a;
    w_ram_wdata = w_gnt_b ? wdata_b : wdata_a;
  end

  // Priority flips to the loser after every grant; rvalid tracks accepted reads one cycle later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prio     <= PORT_A;
      r_rvalid_a <= 1'b0;
      r_rvalid_b <= 1'b0;
    end else begin
      r_rvalid_a <= w_gnt_a && !we_a;
      r_rvalid_b <= w_gnt_b && !we_b;
      if (w_gnt_a) begin
        r_prio <= PORT_B;
      end else if (w_gnt_b) begin
        r_prio <= PORT_A;
      end
    end
  end

  dram_256x32 #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_ram_we),
    .i_addr  (w_ram_addr),
    .i_wdata (w_ram_wdata),
    .o_rdata (rdata)
  );

  assign gnt_a    = w_gnt_a;
  assign gnt_b    = w_gnt_b;
  assign rvalid_a = r_rvalid_a;
  assign rvalid_b = r_rvalid_b;

endmodule : dram_arbiter

// File: tb/tb_dram_arbiter.sv
// Scoreboard bench for dram_arbiter: grants checked each cycle, reads queued and matched on rvalid.
module tb_dram_arbiter;

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_a = 1'b0, req_b = 1'b0, we_a = 1'b0, we_b = 1'b0;
  logic [AW-1:0] addr_a = '0, addr_b = '0;
  logic [DW-1:0] wdata_a = '0, wdata_b = '0;
  logic          gnt_a, gnt_b, rvalid_a, rvalid_b;
  logic [DW-1:0] rdata;

  typedef struct {
    logic          port;
    logic          chk;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } sb_t;

  sb_t           sb[$];
  logic [DW-1:0] m_mem [256];
  bit            m_vld [256];
  logic          m_prio = 1'b0;
  int            total = 0;
  int            bad = 0;

  dram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .req_a(req_a), .req_b(req_b), .we_a(we_a), .we_b(we_b),
    .addr_a(addr_a), .addr_b(addr_b), .wdata_a(wdata_a), .wdata_b(wdata_b),
    .gnt_a(gnt_a), .gnt_b(gnt_b), .rvalid_a(rvalid_a), .rvalid_b(rvalid_b),
    .rdata(rdata)
  );

  always #5 clk = ~clk;

  // One bus cycle: entered at posedge+1. Checks the previous cycle's read return, drives,
  // checks grants at the falling edge, updates the model and queues expected reads.
  task automatic step(input logic ra, input logic wa, input logic [AW-1:0] aa, input logic [DW-1:0] da,
                      input logic rb, input logic wb, input logic [AW-1:0] ab, input logic [DW-1:0] db);
    sb_t  e;
    logic eg_a, eg_b;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      total++;
      if (rvalid_a !== (e.port == 1'b0) || rvalid_b !== (e.port == 1'b1)) begin
        bad++;
        $display("FAIL rvalid port=%0d addr=%02h: got a=%b b=%b", e.port, e.addr, rvalid_a, rvalid_b);
      end
      if (e.chk) begin
        total++;
        if (rdata !== e.data) begin
          bad++;
          $display("FAIL rdata addr=%02h: got %08h want %08h", e.addr, rdata, e.data);
        end
      end
    end else begin
      total++;
      if (rvalid_a !== 1'b0 || rvalid_b !== 1'b0) begin
        bad++;
        $display("FAIL spurious_rvalid: got a=%b b=%b want 0 0", rvalid_a, rvalid_b);
      end
    end
    req_a = ra; we_a = wa; addr_a = aa; wdata_a = da;
    req_b = rb; we_b = wb; addr_b = ab; wdata_b = db;
    eg_a = ra && (!rb || m_prio == 1'b0);
    eg_b = rb && (!ra || m_prio == 1'b1);
    @(negedge clk);
    total++;
    if (gnt_a !== eg_a || gnt_b !== eg_b) begin
      bad++;
      $display("FAIL grant ra=%b rb=%b: got a=%b b=%b want a=%b b=%b", ra, rb, gnt_a, gnt_b, eg_a, eg_b);
    end
    if (eg_a) begin
      if (wa) begin m_mem[aa] = da; m_vld[aa] = 1'b1; end
      else sb.push_back('{port: 1'b0, chk: m_vld[aa], addr: aa, data: m_mem[aa]});
      m_prio = 1'b1;
    end else if (eg_b) begin
      if (wb) begin m_mem[ab] = db; m_vld[ab] = 1'b1; end
      else sb.push_back('{port: 1'b1, chk: m_vld[ab], addr: ab, data: m_mem[ab]});
      m_prio = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic test_reset();
    req_a = 1'b1; req_b = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (gnt_a !== 1'b0 || gnt_b !== 1'b0 || rvalid_a !== 1'b0 || rvalid_b !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs: got gnt=%b%b rvalid=%b%b want 0000", gnt_a, gnt_b, rvalid_a, rvalid_b);
    end
    req_a = 1'b0; req_b = 1'b0;
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
    m_prio = 1'b0;
  endtask

  task automatic test_single_write_read();
    step(1'b1, 1'b1, 8'h10, 32'hDEADBEEF, 1'b0, 1'b0, '0, '0);
    step(1'b1, 1'b0, 8'h10, '0,           1'b0, 1'b0, '0, '0);
    step(1'b1, 1'b1, 8'h01, 32'h1111_0001, 1'b0, 1'b0, '0, '0);
    step(1'b0, 1'b0, '0, '0,              1'b1, 1'b1, 8'h02, 32'h2222_0002);
    idle();
  endtask

  // Read granted, then rst asserted before the closing edge: no rvalid, priority back to A.
  task automatic test_reset_mid_read();
    idle();
    req_a = 1'b1; we_a = 1'b0; addr_a = 8'h10;
    @(negedge clk);
    total++;
    if (gnt_a !== 1'b1 || gnt_b !== 1'b0) begin
      bad++;
      $display("FAIL mid_read_grant: got a=%b b=%b want a=1 b=0", gnt_a, gnt_b);
    end
    rst = 1'b1;
    #1;
    total++;
    if (gnt_a !== 1'b0) begin
      bad++;
      $display("FAIL reset_blocks_grant: got %b want 0", gnt_a);
    end
    @(posedge clk);
    #1;
    total++;
    if (rvalid_a !== 1'b0 || rvalid_b !== 1'b0) begin
      bad++;
      $display("FAIL reset_drops_read: got a=%b b=%b want 0 0", rvalid_a, rvalid_b);
    end
    req_a = 1'b0;
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
    m_prio = 1'b0;
  endtask

  task automatic test_contention();
    repeat (4) step(1'b1, 1'b0, 8'h01, '0, 1'b1, 1'b0, 8'h02, '0);
    idle();
  endtask

  task automatic test_raw_hazard();
    step(1'b0, 1'b0, '0, '0,            1'b1, 1'b1, 8'hFF, 32'h0000_0055);
    step(1'b1, 1'b0, 8'hFF, '0,         1'b0, 1'b0, '0, '0);
    idle();
  endtask

  task automatic test_boundary();
    step(1'b1, 1'b1, 8'h00, 32'hA5A5_0000, 1'b0, 1'b0, '0, '0);
    step(1'b0, 1'b0, '0, '0,               1'b1, 1'b1, 8'hFF, 32'h5A5A_00FF);
    step(1'b1, 1'b1, 8'h7F, 32'h0000_7F7F, 1'b0, 1'b0, '0, '0);
    step(1'b1, 1'b1, 8'h80, 32'h8080_0000, 1'b0, 1'b0, '0, '0);
    step(1'b0, 1'b0, '0, '0,               1'b1, 1'b0, 8'h00, '0);
    step(1'b1, 1'b0, 8'hFF, '0,            1'b0, 1'b0, '0, '0);
    step(1'b1, 1'b0, 8'h7F, '0,            1'b1, 1'b0, 8'h80, '0);
    step(1'b1, 1'b0, 8'h80, '0,            1'b1, 1'b0, 8'h7F, '0);
    idle();
  endtask

  task automatic test_random();
    for (int i = 0; i < 10000; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 32'($urandom),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 32'($urandom));
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_single_write_read();
    test_reset_mid_read();
    test_contention();
    test_raw_hazard();
    test_boundary();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_dram_arbiter
